dm_cache: RTL and testbench

DM_CACHE -- requirements
Module: dm_cache

---
 rtl/dm_cache_pkg.sv | 31 +++
 rtl/dm_cache_if.sv | 39 +++
 rtl/dm_cache_tag_array.sv | 51 +++++
 rtl/dm_cache.sv | 225 ++++++++++++++++++++++
 tb/tb_dm_cache.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_cache_pkg.sv
// dm_cache_pkg: shared FSM state encoding, address-field width helpers and line types.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dm_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    EVICT,
    FILL,
    THRU,
    FLUSH_SCAN,
    FLUSH_WR,
    RESP
  } state_t;

  typedef logic [31:0] word_t;

  // Line type for the default geometry; parameterised modules build their own word_t vector.
  localparam int DEF_LINE_WORDS = 8;
  typedef word_t [DEF_LINE_WORDS-1:0] line_t;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

endpackage

// File: rtl/dm_cache_if.sv
// dm_cache_if: requester strobes plus the line/word memory port of the cache.
// Latency: n/a (wires only).
// Backpressure: requester holds strobes until done; memory strobes held until mem_done.
interface dm_cache_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 8
);
  logic                        r_en;
  logic                        w_en;
  logic                        flush;
  logic                        bypass;
  logic [ADDR_W-1:0]           addr;
  logic [31:0]                 data_store;
  logic [31:0]                 data_load;
  logic                        done;
  logic                        cache_hit;
  logic [LINE_WORDS-1:0][31:0] line_read;
  logic [LINE_WORDS-1:0][31:0] line_store;
  logic                        mem_done;
  logic                        mem_r_line;
  logic                        mem_w_line;
  logic                        mem_r_one;
  logic                        mem_w_one;
  logic [ADDR_W-1:0]           mem_addr;

  // Requester and backing memory side.
  modport master (
    output r_en, w_en, flush, bypass, addr, data_store, line_read, mem_done,
    input  data_load, done, cache_hit, line_store,
    input  mem_r_line, mem_w_line, mem_r_one, mem_w_one, mem_addr
  );

  // Cache side.
  modport slave (
    input  r_en, w_en, flush, bypass, addr, data_store, line_read, mem_done,
    output data_load, done, cache_hit, line_store,
    output mem_r_line, mem_w_line, mem_r_one, mem_w_one, mem_addr
  );
endinterface

// File: rtl/dm_cache_tag_array.sv
// dm_cache_tag_array: per-line valid/dirty/tag storage with combinational lookup at idx.
// Latency: lookup combinational, updates take effect on the next clock edge.
// Backpressure: none; at most one update strobe is active per cycle.
module dm_cache_tag_array
  import dm_cache_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 27
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic [idx_w(NUM_LINES)-1:0]    idx,
  input  logic [TAG_W-1:0]               tag,
  input  logic                           fill,
  input  logic                           fill_dirty,
  input  logic                           set_dirty,
  input  logic                           clr_dirty,
  output logic                           hit,
  output logic                           vld,
  output logic                           dirty,
  output logic [TAG_W-1:0]               vtag
);
  logic [NUM_LINES-1:0] vld_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];

  assign vld   = vld_q[idx];
  assign dirty = dirty_q[idx];
  assign vtag  = tag_q[idx];
  assign hit   = vld_q[idx] && (tag_q[idx] == tag);

  // Valid/dirty bits: cleared on reset, set by fill, dirty toggled by write hits and write-backs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_q   <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      vld_q[idx]   <= 1'b1;
      dirty_q[idx] <= fill_dirty;
    end else if (set_dirty) begin
      dirty_q[idx] <= 1'b1;
    end else if (clr_dirty) begin
      dirty_q[idx] <= 1'b0;
    end
  end

  // Tags are only meaningful while valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (fill) tag_q[idx] <= tag;
  end
endmodule

// File: rtl/dm_cache.sv
// dm_cache: direct-mapped write-back cache with bypass word access and flush; stats via DM_CACHE_STATS_EN.
// Latency: hit done 1 cycle after accept; misses add optional line write-back then line fill.
// Backpressure: accepts only in IDLE, requester holds until done; each memory strobe held until mem_done.
module dm_cache
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int NUM_LINES  = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic      clk,
  input  logic      rst_l,
  dm_cache_if.slave bus
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  typedef word_t [LINE_WORDS-1:0] cline_t;

  state_t           state;
  logic             op_wr;
  logic             op_byp;
  logic [IDX_W-1:0] scan_idx;
  cline_t           data_q [NUM_LINES];
  cline_t           fill_line;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] req_tag;
  logic [TAG_W-1:0] vtag;
  logic             ta_hit, ta_vld, ta_dirty;
  logic             fill_done, wr_word, set_dirty, clr_dirty;

  assign req_off = bus.addr[OFF_W-1:0];
  assign req_idx = bus.addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag = bus.addr[ADDR_W-1:OFF_W+IDX_W];
  assign lk_idx  = ((state == FLUSH_SCAN) || (state == FLUSH_WR)) ? scan_idx : req_idx;

  // Write hits (normal or bypass) patch the cached word when accepted; only normal writes dirty it.
  assign wr_word   = (state == IDLE) && !bus.flush && bus.w_en && ta_hit;
  assign set_dirty = wr_word && !bus.bypass;
  assign fill_done = (state == FILL) && bus.mem_done;
  assign clr_dirty = ((state == EVICT) || (state == FLUSH_WR)) && bus.mem_done;

  dm_cache_tag_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_tags (
    .clk        (clk),
    .rst_l      (rst_l),
    .idx        (lk_idx),
    .tag        (req_tag),
    .fill       (fill_done),
    .fill_dirty (op_wr),
    .set_dirty  (set_dirty),
    .clr_dirty  (clr_dirty),
    .hit        (ta_hit),
    .vld        (ta_vld),
    .dirty      (ta_dirty),
    .vtag       (vtag)
  );

  // Incoming fill line, with the pending store merged in for write misses.
  always_comb begin
    fill_line = bus.line_read;
    if (op_wr) fill_line[req_off] = bus.data_store;
  end

  // Data array: line load on fill completion, single-word update on write hit.
  always_ff @(posedge clk) begin
    if (fill_done) data_q[req_idx] <= fill_line;
    else if (wr_word) data_q[req_idx][req_off] <= bus.data_store;
  end

  // Control FSM with registered handshake and memory-port outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state          <= IDLE;
      op_wr          <= 1'b0;
      op_byp         <= 1'b0;
      scan_idx       <= '0;
      bus.done       <= 1'b0;
      bus.cache_hit  <= 1'b0;
      bus.data_load  <= '0;
      bus.line_store <= '0;
      bus.mem_r_line <= 1'b0;
      bus.mem_w_line <= 1'b0;
      bus.mem_r_one  <= 1'b0;
      bus.mem_w_one  <= 1'b0;
      bus.mem_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush) begin
            scan_idx <= '0;
            state    <= FLUSH_SCAN;
          end else if (bus.w_en || bus.r_en) begin
            op_wr  <= bus.w_en;
            op_byp <= bus.bypass;
            if (bus.bypass && bus.w_en) begin
              bus.mem_w_one     <= 1'b1;
              bus.mem_addr      <= bus.addr;
              bus.line_store    <= '0;
              bus.line_store[0] <= bus.data_store;
              state             <= THRU;
            end else if (bus.bypass && !(ta_hit && ta_dirty)) begin
              bus.mem_r_one <= 1'b1;
              bus.mem_addr  <= bus.addr;
              state         <= THRU;
            end else if (!bus.bypass && ta_hit) begin
              bus.done      <= 1'b1;
              bus.cache_hit <= 1'b1;
              if (!bus.w_en) bus.data_load <= data_q[req_idx][req_off];
              state         <= SERVE;
            end else if (ta_vld && ta_dirty) begin
              bus.mem_w_line <= 1'b1;
              bus.mem_addr   <= {vtag, req_idx, {OFF_W{1'b0}}};
              bus.line_store <= data_q[req_idx];
              state          <= EVICT;
            end else begin
              bus.mem_r_line <= 1'b1;
              bus.mem_addr   <= {req_tag, req_idx, {OFF_W{1'b0}}};
              state          <= FILL;
            end
          end
        end
        SERVE, RESP: begin
          bus.done      <= 1'b0;
          bus.cache_hit <= 1'b0;
          state         <= IDLE;
        end
        EVICT: begin
          if (bus.mem_done) begin
            bus.mem_w_line <= 1'b0;
            if (op_byp) begin
              bus.mem_r_one <= 1'b1;
              bus.mem_addr  <= bus.addr;
              state         <= THRU;
            end else begin
              bus.mem_r_line <= 1'b1;
              bus.mem_addr   <= {req_tag, req_idx, {OFF_W{1'b0}}};
              state          <= FILL;
            end
          end
        end
        FILL: begin
          if (bus.mem_done) begin
            bus.mem_r_line <= 1'b0;
            bus.done       <= 1'b1;
            bus.cache_hit  <= 1'b0;
            if (!op_wr) bus.data_load <= bus.line_read[req_off];
            state          <= SERVE;
          end
        end
        THRU: begin
          if (bus.mem_done) begin
            bus.mem_r_one <= 1'b0;
            bus.mem_w_one <= 1'b0;
            bus.done      <= 1'b1;
            bus.cache_hit <= ta_hit;
            if (!op_wr) bus.data_load <= bus.line_read[0];
            state         <= RESP;
          end
        end
        FLUSH_SCAN: begin
          if (ta_vld && ta_dirty) begin
            bus.mem_w_line <= 1'b1;
            bus.mem_addr   <= {vtag, scan_idx, {OFF_W{1'b0}}};
            bus.line_store <= data_q[scan_idx];
            state          <= FLUSH_WR;
          end else if (scan_idx == LAST_IDX) begin
            bus.done <= 1'b1;
            state    <= RESP;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        FLUSH_WR: begin
          if (bus.mem_done) begin
            bus.mem_w_line <= 1'b0;
            if (scan_idx == LAST_IDX) begin
              bus.done <= 1'b1;
              state    <= RESP;
            end else begin
              scan_idx <= scan_idx + IDX_W'(1);
              state    <= FLUSH_SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DM_CACHE_STATS_EN
  logic st_flush;

  // Saturating hit/miss counters, bumped once on the done pulse of each non-flush request.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      st_flush   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE && bus.flush) st_flush <= 1'b1;
      else if (state == IDLE && (bus.r_en || bus.w_en)) st_flush <= 1'b0;
      if (bus.done && !st_flush) begin
        if (bus.cache_hit) begin
          if (hit_count != '1) hit_count <= hit_count + 32'd1;
        end else begin
          if (miss_count != '1) miss_count <= miss_count + 32'd1;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_dm_cache.sv
// tb_dm_cache: directed scoreboard bench for dm_cache (4 lines x 8 words).
// Expected memory ops and completions are queued at issue and checked by a negedge monitor.
// A behavioural memory answers each strobe after two cycles unless held off.
module tb_dm_cache;
  import dm_cache_pkg::*;

  localparam logic [3:0] R_LINE = 4'b1000;
  localparam logic [3:0] W_LINE = 4'b0100;
  localparam logic [3:0] R_ONE  = 4'b0010;
  localparam logic [3:0] W_ONE  = 4'b0001;

  typedef struct {
    logic [3:0]  vec;
    logic [31:0] addr;
    int          word;
    logic [31:0] val;
  } mem_exp_t;

  typedef struct {
    bit          chk_data;
    logic [31:0] data;
    logic        hit;
  } done_exp_t;

  logic clk;
  logic rst_l;
  logic mem_hold;
  int   nvec;
  int   nerr;
  logic [31:0] mem [0:255];
  mem_exp_t  mem_q[$];
  done_exp_t done_q[$];

  dm_cache_if #(.ADDR_W(32), .LINE_WORDS(8)) bus ();

`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dm_cache #(.ADDR_W(32), .NUM_LINES(4), .LINE_WORDS(8)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
`ifdef DM_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic [3:0] v, input logic [31:0] a, input int w, input logic [31:0] val);
    mem_exp_t e;
    e.vec = v; e.addr = a; e.word = w; e.val = val;
    mem_q.push_back(e);
  endtask

  task automatic exp_done(input bit cd, input logic [31:0] d, input logic h);
    done_exp_t e;
    e.chk_data = cd; e.data = d; e.hit = h;
    done_q.push_back(e);
  endtask

  // Drive one request, wait (bounded) for done, check latency when given, then release strobes.
  task automatic req(input string name, input bit r, input bit w, input bit f, input bit b,
                     input logic [31:0] a, input logic [31:0] d, input int lat);
    int cyc;
    @(negedge clk);
    bus.r_en = r; bus.w_en = w; bus.flush = f; bus.bypass = b;
    bus.addr = a; bus.data_store = d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.done && cyc < 200);
    if (!bus.done) begin
      nvec++; nerr++;
      $display("FAIL %s_timeout: no done after %0d cycles, expected done", name, cyc);
    end else if (lat >= 0) begin
      chk({name, "_latency"}, cyc, lat);
    end
    bus.r_en = 1'b0; bus.w_en = 1'b0; bus.flush = 1'b0; bus.bypass = 1'b0;
  endtask

  // Scoreboard monitor: new memory strobes and done pulses are matched against the queues.
  initial begin : monitor
    logic [3:0] prev_vec;
    logic [3:0] vec;
    mem_exp_t   me;
    done_exp_t  de;
    prev_vec = 4'b0;
    forever begin
      @(negedge clk);
      vec = {bus.mem_r_line, bus.mem_w_line, bus.mem_r_one, bus.mem_w_one};
      if (vec != 4'b0 && vec != prev_vec) begin
        if (mem_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_mem_op: got strobes %b addr %h, expected none", vec, bus.mem_addr);
        end else begin
          me = mem_q.pop_front();
          chk("mem_strobe", {28'b0, vec}, {28'b0, me.vec});
          chk("mem_addr", bus.mem_addr, me.addr);
          if (me.word >= 0) chk("line_store_word", bus.line_store[me.word], me.val);
        end
      end
      prev_vec = vec;
      if (bus.done) begin
        if (done_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_done: got done, expected none");
        end else begin
          de = done_q.pop_front();
          chk("cache_hit", {31'b0, bus.cache_hit}, {31'b0, de.hit});
          if (de.chk_data) chk("data_load", bus.data_load, de.data);
        end
      end
    end
  end

  // Behavioural backing memory: responds two cycles into each strobe.
  initial begin : responder
    int cnt;
    logic [7:0] ma;
    cnt = 0;
    bus.mem_done = 1'b0;
    bus.line_read = '0;
    forever begin
      @(negedge clk);
      ma = bus.mem_addr[7:0];
      if (!rst_l) begin
        cnt = 0;
        bus.mem_done = 1'b0;
      end else if (bus.mem_done) begin
        bus.mem_done = 1'b0;
        cnt = 0;
      end else if (!mem_hold && (bus.mem_r_line || bus.mem_w_line || bus.mem_r_one || bus.mem_w_one)) begin
        cnt++;
        if (cnt >= 2) begin
          if (bus.mem_r_line) for (int i = 0; i < 8; i++) bus.line_read[i] = mem[8'(ma + i)];
          if (bus.mem_w_line) for (int i = 0; i < 8; i++) mem[8'(ma + i)] = bus.line_store[i];
          if (bus.mem_r_one) begin
            bus.line_read = '0;
            bus.line_read[0] = mem[ma];
          end
          if (bus.mem_w_one) mem[ma] = bus.line_store[0];
          bus.mem_done = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int cyc;
    nvec = 0; nerr = 0; mem_hold = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[8'h13] = 32'hDEAD_BEEF;
    rst_l = 1'b0;
    bus.r_en = 1'b0; bus.w_en = 1'b0; bus.flush = 1'b0; bus.bypass = 1'b0;
    bus.addr = '0; bus.data_store = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_cache_hit", {31'b0, bus.cache_hit}, 32'd0);
    chk("rst_strobes", {28'b0, bus.mem_r_line, bus.mem_w_line, bus.mem_r_one, bus.mem_w_one}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    rst_l = 1'b1;

    // Cold read miss, then the same word hits one cycle after accept.
    exp_mem(R_LINE, 32'h10, -1, 0); exp_done(1, 32'hDEAD_BEEF, 0);
    req("cold_read", 1, 0, 0, 0, 32'h13, 0, -1);
    exp_done(1, 32'hDEAD_BEEF, 1);
    req("read_hit", 1, 0, 0, 0, 32'h13, 0, 1);
`ifdef DM_CACHE_STATS_EN
    @(negedge clk);
    chk("hit_count", hit_count, 32'd1);
    chk("miss_count", miss_count, 32'd1);
`endif

    // Write hit dirties the line; conflicting read writes it back then fills.
    exp_done(0, 0, 1);
    req("write_hit", 0, 1, 0, 0, 32'h13, 32'h1234_5678, 1);
    exp_mem(W_LINE, 32'h10, 3, 32'h1234_5678); exp_mem(R_LINE, 32'h30, -1, 0);
    exp_done(1, 32'h1000_0033, 0);
    req("evict_read", 1, 0, 0, 0, 32'h33, 0, -1);
    exp_mem(R_LINE, 32'h10, -1, 0); exp_done(1, 32'h1234_5678, 0);
    req("refill_clean", 1, 0, 0, 0, 32'h13, 0, -1);

    // Bypass write updates memory and the cached copy; bypass read of a clean line.
    exp_mem(W_ONE, 32'h14, 0, 32'hCAFE_F00D); exp_done(0, 0, 1);
    req("byp_write", 0, 1, 0, 1, 32'h14, 32'hCAFE_F00D, -1);
    exp_done(1, 32'hCAFE_F00D, 1);
    req("read_after_byp", 1, 0, 0, 0, 32'h14, 0, 1);
    exp_mem(R_ONE, 32'h14, -1, 0); exp_done(1, 32'hCAFE_F00D, 1);
    req("byp_read_clean", 1, 0, 0, 1, 32'h14, 0, -1);

    // Dirty lines 0x00 and 0x10, flush writes both back in index order with one done.
    exp_mem(R_LINE, 32'h00, -1, 0); exp_done(0, 0, 0);
    req("write_miss", 0, 1, 0, 0, 32'h02, 32'hAAAA_0002, -1);
    exp_done(0, 0, 1);
    req("write_hit2", 1, 1, 0, 0, 32'h11, 32'hBBBB_0011, 1);
    exp_mem(W_LINE, 32'h00, 2, 32'hAAAA_0002); exp_mem(W_LINE, 32'h10, 1, 32'hBBBB_0011);
    exp_done(0, 0, 0);
    req("flush_dirty", 1, 0, 1, 0, 32'h0, 0, -1);
    exp_mem(R_LINE, 32'h20, -1, 0); exp_done(1, 32'h1000_0021, 0);
    req("post_flush_a", 1, 0, 0, 0, 32'h21, 0, -1);
    exp_mem(R_LINE, 32'h30, -1, 0); exp_done(1, 32'h1000_0031, 0);
    req("post_flush_b", 1, 0, 0, 0, 32'h31, 0, -1);
    exp_done(0, 0, 0);
    req("flush_clean", 0, 0, 1, 0, 32'h0, 0, 5);

    // Bypass read of a dirty line evicts first, leaving it valid and clean.
    exp_done(0, 0, 1);
    req("write_hit3", 0, 1, 0, 0, 32'h31, 32'hDDDD_0031, 1);
    exp_mem(W_LINE, 32'h30, 1, 32'hDDDD_0031); exp_mem(R_ONE, 32'h31, -1, 0);
    exp_done(1, 32'hDDDD_0031, 1);
    req("byp_read_dirty", 1, 0, 0, 1, 32'h31, 0, -1);
    exp_mem(R_LINE, 32'h10, -1, 0); exp_done(1, 32'hBBBB_0011, 0);
    req("evict_clean", 1, 0, 0, 0, 32'h11, 0, -1);

    // Reset in the middle of a fill drops strobes immediately and invalidates the cache.
    exp_mem(R_LINE, 32'h50, -1, 0);
    mem_hold = 1'b1;
    @(negedge clk);
    bus.r_en = 1'b1; bus.addr = 32'h53;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.mem_r_line && cyc < 20);
    chk("fill_started", {31'b0, bus.mem_r_line}, 32'd1);
    rst_l = 1'b0;
    #1;
    chk("midfill_rst_strobes", {28'b0, bus.mem_r_line, bus.mem_w_line, bus.mem_r_one, bus.mem_w_one}, 32'd0);
    chk("midfill_rst_done", {31'b0, bus.done}, 32'd0);
    bus.r_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    mem_hold = 1'b0;
    exp_mem(R_LINE, 32'h10, -1, 0); exp_done(1, 32'h1234_5678, 0);
    req("post_reset_miss", 1, 0, 0, 0, 32'h13, 0, -1);

    repeat (5) @(negedge clk);
    chk("mem_q_drained", mem_q.size(), 32'd0);
    chk("done_q_drained", done_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
